// File: rtl/zvc_pkg.sv
// zvc_pkg: shared geometry, widths and types for the zero-value compressor
// line scheduler.
//   - LIFM / MT line geometry and the derived flat line widths
//   - NNZ_WIDTH: width of a non-zero word count for one line
//   - tag_t: per-line bookkeeping carried alongside the compressor
//   - count_ones / id_width helpers
package zvc_pkg;

  localparam int WORD_WIDTH      = 8;
  localparam int LINE_SIZE       = 128;
  localparam int DIST_WIDTH      = 7;
  localparam int MAX_LIFM_RSIZ   = 4;
  localparam int MT_WORD_WIDTH   = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int LIFM_LINE_WIDTH = LINE_SIZE * WORD_WIDTH;
  localparam int MT_LINE_WIDTH   = LINE_SIZE * MT_WORD_WIDTH;
  localparam int NNZ_WIDTH       = $clog2(LINE_SIZE + 1);

  // Wide enough for the largest supported requester count (8).
  localparam int MAX_ID_WIDTH = 3;

  typedef struct packed {
    logic                    valid;
    logic [MAX_ID_WIDTH-1:0] id;
    logic [NNZ_WIDTH-1:0]    nnz;
  } tag_t;

  function automatic logic [NNZ_WIDTH-1:0] count_ones(input logic [LINE_SIZE-1:0] bits);
    logic [NNZ_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      n = n + NNZ_WIDTH'(bits[i]);
    end
    return n;
  endfunction

  // Requester ID width, never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/zvc_result_fifo.sv
// zvc_result_fifo: first-word-fall-through FIFO for compressed results.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   push, push_data     write one entry
//   pop                 consumer ready; pops only when an entry is present
//   out_valid, out_data head entry (out_data holds its last value when empty)
//   count               number of stored entries
module zvc_result_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d, rd_inc, wr_inc;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  pop_en;

  always_comb begin
    pop_en = pop && (cnt_q != '0);
    rd_inc = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    wr_inc = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    rd_d   = pop_en ? rd_inc : rd_q;
    wr_d   = push ? wr_inc : wr_q;

    cnt_d = cnt_q;
    if (push && !pop_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop_en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // The head is kept in its own register so the output holds its last
    // value once the FIFO drains. When the next head is the slot being
    // written this cycle (push into empty, or push+pop at one entry) it
    // must bypass the memory.
    head_d = head_q;
    if (cnt_d != '0) begin
      head_d = (push && (rd_d == wr_q)) ? push_data : mem[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  // Issue credit upstream must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && !pop_en && (cnt_q == CNT_W'(DEPTH))));
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = head_q;
  assign count     = cnt_q;

endmodule

// File: rtl/zvc_line_scheduler.sv
// zvc_line_scheduler: shares one zero-value compressor between NUM_REQ line
// producers.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/req_ready          per-requester handshake (ready is one-hot or 0)
//   req_lifm, req_mt             flat requester lines, requester r at slice r
//   cmp_lifm_line, cmp_mt_line   registered line towards the compressor
//   cmp_lifm_comp, cmp_mt_comp   compressor result, COMP_LATENCY cycles later
//   out_valid/out_ready          result stream handshake
//   out_lifm, out_mt             compressed lines
//   out_req_id, out_nnz          originating requester, non-zero word count
//   busy                         a line is in flight or buffered
module zvc_line_scheduler
  import zvc_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int COMP_LATENCY = 1,
  parameter  int FIFO_DEPTH   = 4,
  localparam int ID_WIDTH     = id_width(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*LIFM_LINE_WIDTH-1:0] req_lifm,
  input  logic [NUM_REQ*MT_LINE_WIDTH-1:0]   req_mt,
  output logic [LIFM_LINE_WIDTH-1:0]         cmp_lifm_line,
  output logic [MT_LINE_WIDTH-1:0]           cmp_mt_line,
  input  logic [LIFM_LINE_WIDTH-1:0]         cmp_lifm_comp,
  input  logic [MT_LINE_WIDTH-1:0]           cmp_mt_comp,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LIFM_LINE_WIDTH-1:0]         out_lifm,
  output logic [MT_LINE_WIDTH-1:0]           out_mt,
  output logic [ID_WIDTH-1:0]                out_req_id,
  output logic [NNZ_WIDTH-1:0]               out_nnz,
  output logic                               busy
);

  localparam int FIFO_DW = LIFM_LINE_WIDTH + MT_LINE_WIDTH + ID_WIDTH + NNZ_WIDTH;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [ID_WIDTH-1:0]        rr_q, rr_d;
  logic [LIFM_LINE_WIDTH-1:0] cmp_lifm_q, cmp_lifm_d;
  logic [MT_LINE_WIDTH-1:0]   cmp_mt_q, cmp_mt_d;
  // Stage 0 lines up with cmp_*_line; the last stage lines up with cmp_*_comp.
  tag_t                       tag_q [COMP_LATENCY+1];
  tag_t                       tag_d [COMP_LATENCY+1];
  tag_t                       exit_tag;
  logic [MAX_ID_WIDTH-1:0]    unused_exit_id;

  logic [FCNT_W-1:0]          fifo_count;
  logic [FIFO_DW-1:0]         fifo_out;
  int                         inflight;
  logic                       can_issue;
  logic                       grant_any;
  logic [ID_WIDTH-1:0]        grant_id;
  logic [LIFM_LINE_WIDTH-1:0] sel_lifm;
  logic [MT_LINE_WIDTH-1:0]   sel_mt;
  logic [LINE_SIZE-1:0]       word_nz;

  // Credit: every valid tag will land in the FIFO, so it already owns a slot.
  always_comb begin
    inflight = 0;
    for (int s = 0; s <= COMP_LATENCY; s++) begin
      inflight += int'(tag_q[s].valid);
    end
    can_issue = (inflight + int'(fifo_count)) < FIFO_DEPTH;
  end

  // Round-robin: first valid requester at or after rr_q, circularly.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (reset_n && can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_REQ) begin
          idx -= NUM_REQ;
        end
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = ID_WIDTH'(idx);
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign sel_lifm = req_lifm[int'(grant_id)*LIFM_LINE_WIDTH +: LIFM_LINE_WIDTH];
  assign sel_mt   = req_mt[int'(grant_id)*MT_LINE_WIDTH +: MT_LINE_WIDTH];

  for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_word_nz
    assign word_nz[gi] = |sel_lifm[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  always_comb begin
    cmp_lifm_d   = grant_any ? sel_lifm : '0;
    cmp_mt_d     = grant_any ? sel_mt : '0;
    tag_d[0]     = '0;
    if (grant_any) begin
      tag_d[0].valid = 1'b1;
      tag_d[0].id    = MAX_ID_WIDTH'(grant_id);
      tag_d[0].nnz   = count_ones(word_nz);
    end
    for (int s = 1; s <= COMP_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q       <= '0;
      cmp_lifm_q <= '0;
      cmp_mt_q   <= '0;
      for (int s = 0; s <= COMP_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      cmp_lifm_q <= cmp_lifm_d;
      cmp_mt_q   <= cmp_mt_d;
      for (int s = 0; s <= COMP_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign exit_tag       = tag_q[COMP_LATENCY];
  assign unused_exit_id = exit_tag.id;

  zvc_result_fifo #(
    .DATA_WIDTH (FIFO_DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (exit_tag.valid),
    .push_data ({cmp_lifm_comp, cmp_mt_comp, exit_tag.id[ID_WIDTH-1:0], exit_tag.nnz}),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign {out_lifm, out_mt, out_req_id, out_nnz} = fifo_out;

  assign cmp_lifm_line = cmp_lifm_q;
  assign cmp_mt_line   = cmp_mt_q;
  assign busy          = (inflight != 0) || (fifo_count != '0);

endmodule

// File: tb/tb_zvc_line_scheduler.sv
// Directed bench for zvc_line_scheduler with a behavioural one-cycle
// zero-value compressor (non-zero LIFM words and their MT words packed to
// the front of the line).
module tb_zvc_line_scheduler;

  localparam int WW  = 8;
  localparam int LS  = 128;
  localparam int MTW = 28;
  localparam int LW  = LS * WW;
  localparam int MW  = LS * MTW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [LW-1:0] lifm0, lifm1;
  logic [MW-1:0] mt0, mt1;
  logic [LW-1:0] cmp_lifm_line, cmp_lifm_comp, out_lifm;
  logic [MW-1:0] cmp_mt_line, cmp_mt_comp, out_mt;
  logic          out_valid, out_ready, busy;
  logic [0:0]    out_req_id;
  logic [7:0]    out_nnz;

  zvc_line_scheduler #(
    .NUM_REQ      (2),
    .COMP_LATENCY (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_lifm      ({lifm1, lifm0}),
    .req_mt        ({mt1, mt0}),
    .cmp_lifm_line (cmp_lifm_line),
    .cmp_mt_line   (cmp_mt_line),
    .cmp_lifm_comp (cmp_lifm_comp),
    .cmp_mt_comp   (cmp_mt_comp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lifm      (out_lifm),
    .out_mt        (out_mt),
    .out_req_id    (out_req_id),
    .out_nnz       (out_nnz),
    .busy          (busy)
  );

  // Compressor model, shares reset_n with the scheduler.
  logic [LW-1:0] comp_lifm_d;
  logic [MW-1:0] comp_mt_d;
  always_comb begin
    int n;
    n           = 0;
    comp_lifm_d = '0;
    comp_mt_d   = '0;
    for (int i = 0; i < LS; i++) begin
      if (cmp_lifm_line[i*WW +: WW] != '0) begin
        comp_lifm_d[n*WW +: WW]  = cmp_lifm_line[i*WW +: WW];
        comp_mt_d[n*MTW +: MTW]  = cmp_mt_line[i*MTW +: MTW];
        n++;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmp_lifm_comp <= '0;
      cmp_mt_comp   <= '0;
    end else begin
      cmp_lifm_comp <= comp_lifm_d;
      cmp_mt_comp   <= comp_mt_d;
    end
  end

  int total = 0;
  int bad   = 0;
  int seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed[255:0]=%h expected[255:0]=%h", tag, obs[255:0], exp[255:0]);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [LW-1:0] exp_p0_lifm, exp_p1_lifm;
  logic [MW-1:0] exp_p0_mt, exp_p1_mt;
  logic [1:0]    exp_grant [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  int            exp_id    [4] = '{1, 0, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b0;
    lifm0 = '0; lifm1 = '0; mt0 = '0; mt1 = '0;

    // Pattern 0 (req0): words 3,8,15 = 13,47,22, MT word 1 at each.
    lifm0[3*WW +: WW] = 8'd13; lifm0[8*WW +: WW] = 8'd47; lifm0[15*WW +: WW] = 8'd22;
    mt0[3*MTW +: MTW] = 28'd1; mt0[8*MTW +: MTW] = 28'd1; mt0[15*MTW +: MTW] = 28'd1;
    exp_p0_lifm = '0; exp_p0_mt = '0;
    exp_p0_lifm[0 +: WW] = 8'd13; exp_p0_lifm[WW +: WW] = 8'd47; exp_p0_lifm[2*WW +: WW] = 8'd22;
    exp_p0_mt[0 +: MTW] = 28'd1; exp_p0_mt[MTW +: MTW] = 28'd1; exp_p0_mt[2*MTW +: MTW] = 28'd1;
    // Pattern 1 (req1): words 5,32,75 = 15,74,35, MT word 2 at each.
    lifm1[5*WW +: WW] = 8'd15; lifm1[32*WW +: WW] = 8'd74; lifm1[75*WW +: WW] = 8'd35;
    mt1[5*MTW +: MTW] = 28'd2; mt1[32*MTW +: MTW] = 28'd2; mt1[75*MTW +: MTW] = 28'd2;
    exp_p1_lifm = '0; exp_p1_mt = '0;
    exp_p1_lifm[0 +: WW] = 8'd15; exp_p1_lifm[WW +: WW] = 8'd74; exp_p1_lifm[2*WW +: WW] = 8'd35;
    exp_p1_mt[0 +: MTW] = 28'd2; exp_p1_mt[MTW +: MTW] = 28'd2; exp_p1_mt[2*MTW +: MTW] = 28'd2;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_id", 64'(out_req_id), 64'(0));
    chk("rst_out_nnz", 64'(out_nnz), 64'(0));
    chk_wide("rst_out_lifm", MW'(out_lifm), MW'(0));
    chk_wide("rst_cmp_lifm", MW'(cmp_lifm_line), MW'(0));
    reset_n = 1'b1;
    tick();

    // Single line from req0, 1 + 1 + 1 cycle latency
    out_ready = 1'b1;
    req_valid = 2'b01;
    settle();
    chk("t1_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    chk_wide("t1_cmp_lifm", MW'(cmp_lifm_line), MW'(lifm0));
    chk_wide("t1_cmp_mt", cmp_mt_line, mt0);
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_early1", 64'(out_valid), 64'(0));
    tick();
    chk("t1_early2", 64'(out_valid), 64'(0));
    tick();
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_id", 64'(out_req_id), 64'(0));
    chk("t1_nnz", 64'(out_nnz), 64'(3));
    chk_wide("t1_lifm", MW'(out_lifm), MW'(exp_p0_lifm));
    chk_wide("t1_mt", out_mt, exp_p0_mt);
    tick();
    chk("t1_one_cycle", 64'(out_valid), 64'(0));
    chk("t1_idle", 64'(busy), 64'(0));

    // Both requesters valid; rr pointer sits at 1 after the req0 grant
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      settle();
      if (k < 4) chk($sformatf("t2_grant%0d", k), 64'(req_ready), 64'(exp_grant[k]));
      tick();
      if (k >= 2) begin
        chk($sformatf("t2_valid%0d", k - 2), 64'(out_valid), 64'(1));
        chk($sformatf("t2_id%0d", k - 2), 64'(out_req_id), 64'(exp_id[k-2]));
        chk($sformatf("t2_nnz%0d", k - 2), 64'(out_nnz), 64'(3));
        chk_wide($sformatf("t2_lifm%0d", k - 2), MW'(out_lifm),
                 MW'((exp_id[k-2] == 1) ? exp_p1_lifm : exp_p0_lifm));
      end
    end
    tick();
    chk("t2_drained", 64'(out_valid), 64'(0));

    // Backpressure: only FIFO_DEPTH lines may be issued
    out_ready = 1'b0;
    req_valid = 2'b01;
    mt0 = '0;
    for (int k = 0; k < 8; k++) begin
      lifm0 = '0;
      lifm0[7:0] = 8'(k + 1);
      settle();
      chk($sformatf("t3_grant%0d", k), 64'(req_ready), 64'((k < 4) ? 2'b01 : 2'b00));
      tick();
    end
    lifm0 = '0;
    lifm0[7:0] = 8'd5;
    for (int d = 0; d < 5; d++) begin
      if (d == 0) out_ready = 1'b1;
      if (d == 2) req_valid = 2'b00;
      settle();
      if (d < 2) chk($sformatf("t3_resume%0d", d), 64'(req_ready), 64'((d == 0) ? 2'b00 : 2'b01));
      chk($sformatf("t3_valid%0d", d), 64'(out_valid), 64'(1));
      chk($sformatf("t3_head%0d", d), 64'(out_lifm[7:0]), 64'(d + 1));
      chk($sformatf("t3_nnz%0d", d), 64'(out_nnz), 64'(1));
      tick();
    end
    chk("t3_empty", 64'(out_valid), 64'(0));
    chk("t3_hold", 64'(out_lifm[7:0]), 64'(5));
    chk("t3_idle", 64'(busy), 64'(0));
    tick();
    chk("t3_pop_empty_valid", 64'(out_valid), 64'(0));
    chk("t3_pop_empty_hold", 64'(out_lifm[7:0]), 64'(5));

    // All-zero line still produces one result
    lifm0 = '0;
    req_valid = 2'b01;
    settle();
    chk("t4_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    tick(); tick();
    chk("t4_valid", 64'(out_valid), 64'(1));
    chk("t4_nnz", 64'(out_nnz), 64'(0));
    chk("t4_id", 64'(out_req_id), 64'(0));
    chk_wide("t4_lifm", MW'(out_lifm), MW'(0));
    chk_wide("t4_mt", out_mt, MW'(0));
    tick();
    chk("t4_once", 64'(out_valid), 64'(0));

    // Reset with two lines in flight and two buffered
    out_ready = 1'b0;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      lifm0 = '0;
      lifm0[7:0] = 8'(8'h21 + k);
      settle();
      chk($sformatf("t5_grant%0d", k), 64'(req_ready), 64'(2'b01));
      tick();
    end
    req_valid = 2'b00;
    chk("t5_pre_valid", 64'(out_valid), 64'(1));
    reset_n = 1'b0;
    tick();
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_ready", 64'(req_ready), 64'(0));
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t5_no_stale", 64'(seen), 64'(0));
    chk("t5_idle", 64'(busy), 64'(0));

    // Push and pop together at FIFO_DEPTH-1 occupancy
    out_ready = 1'b0;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      lifm0 = '0;
      lifm0[7:0] = 8'(8'h31 + k);
      settle();
      chk($sformatf("t6a_grant%0d", k), 64'(req_ready), 64'(2'b01));
      tick();
    end
    req_valid = 2'b00;
    tick();
    out_ready = 1'b1;
    settle();
    chk("t6a_head0", 64'(out_lifm[7:0]), 64'(8'h31));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6a_busy%0d", k), 64'(busy), 64'((k < 3) ? 1 : 0));
      chk($sformatf("t6a_valid%0d", k), 64'(out_valid), 64'((k < 3) ? 1 : 0));
      if (k < 3) chk($sformatf("t6a_head%0d", k + 1), 64'(out_lifm[7:0]), 64'(8'h32 + k));
    end

    // Ten back-to-back lines with the consumer always ready
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        req_valid = 2'b01;
        lifm0 = '0;
        lifm0[7:0] = 8'(8'h41 + k);
      end else begin
        req_valid = 2'b00;
      end
      settle();
      if (k < 10) chk($sformatf("t6b_grant%0d", k), 64'(req_ready), 64'(2'b01));
      tick();
      if (k >= 2) begin
        chk($sformatf("t6b_valid%0d", k - 2), 64'(out_valid), 64'(1));
        chk($sformatf("t6b_head%0d", k - 2), 64'(out_lifm[7:0]), 64'(8'h41 + k - 2));
        chk($sformatf("t6b_busy%0d", k - 2), 64'(busy), 64'(1));
      end
    end
    tick();
    chk("t6b_empty", 64'(out_valid), 64'(0));
    chk("t6b_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
